// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11 UART reporter: FSM states, ASCII codes, frame length.
package dht_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [7:0] CH_H       = 8'h48;
    localparam logic [7:0] CH_T       = 8'h54;
    localparam logic [7:0] CH_EQ      = 8'h3D;
    localparam logic [7:0] CH_SP      = 8'h20;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam int unsigned FRAME_LEN = 13;

    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return ASCII_ZERO + {4'b0000, nib};
    endfunction

endpackage

// File: rtl/dht_uart_reporter_bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits in 8 cycles, done pulses once.
module bin2bcd8
    import dht_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [19:0] sr_q;
    logic [19:0] sr_adj;
    logic [2:0]  iter_q;
    logic        run_q;

    // Add-3 correction on each BCD nibble before the shift
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_adj[8 + 4 * i +: 4] >= 4'd5) begin
                sr_adj[8 + 4 * i +: 4] = sr_adj[8 + 4 * i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q   <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr_q   <= {12'd0, bin};
                iter_q <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                sr_q   <= {sr_adj[18:0], 1'b0};
                iter_q <= iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr_q[19:8];

endmodule

// File: rtl/dht_uart_reporter.sv
// Captures each new DHT11 reading and sends "H=hhh T=ttt\r\n" over an 8N1 UART TX line.
module dht_uart_reporter
    import dht_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic       valid,
    output logic       tx,
    output logic       busy,
    output logic       dropped
);

    localparam int unsigned   CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IdxLast = 4'(FRAME_LEN - 1);

    state_e          state_q;
    logic [7:0]      last_h, last_t;
    logic            last_valid;
    logic            pend_q;
    logic [7:0]      pend_h, pend_t;
    logic [3:0]      idx_q;
    logic [2:0]      bit_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      shreg_q;

    logic            new_sample, capture;
    logic [7:0]      cap_h, cap_t, frame_byte;
    logic [11:0]     bcd_h, bcd_t;
    logic            done_h, done_t;

    assign new_sample = valid & (~last_valid | (humidity != last_h) | (temperature != last_t));
    assign capture    = (state_q == StIdle) & (new_sample | pend_q);
    // A fresh reading in the capture cycle is newer than anything pending
    assign cap_h      = new_sample ? humidity : pend_h;
    assign cap_t      = new_sample ? temperature : pend_t;

    bin2bcd8 u_bcd_h (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (capture),
        .bin     (cap_h),
        .bcd     (bcd_h),
        .done    (done_h)
    );

    bin2bcd8 u_bcd_t (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (capture),
        .bin     (cap_t),
        .bcd     (bcd_t),
        .done    (done_t)
    );

    always_comb begin
        frame_byte = CH_LF;
        unique case (idx_q)
            4'd0:    frame_byte = CH_H;
            4'd1:    frame_byte = CH_EQ;
            4'd2:    frame_byte = digit_char(bcd_h[11:8]);
            4'd3:    frame_byte = digit_char(bcd_h[7:4]);
            4'd4:    frame_byte = digit_char(bcd_h[3:0]);
            4'd5:    frame_byte = CH_SP;
            4'd6:    frame_byte = CH_T;
            4'd7:    frame_byte = CH_EQ;
            4'd8:    frame_byte = digit_char(bcd_t[11:8]);
            4'd9:    frame_byte = digit_char(bcd_t[7:4]);
            4'd10:   frame_byte = digit_char(bcd_t[3:0]);
            4'd11:   frame_byte = CH_CR;
            default: frame_byte = CH_LF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tx         <= 1'b1;
            busy       <= 1'b0;
            dropped    <= 1'b0;
            last_h     <= '0;
            last_t     <= '0;
            last_valid <= 1'b0;
            pend_q     <= 1'b0;
            pend_h     <= '0;
            pend_t     <= '0;
            idx_q      <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
        end else begin
            dropped    <= 1'b0;
            last_valid <= valid;
            if (new_sample) begin
                last_h <= humidity;
                last_t <= temperature;
            end
            if (new_sample && state_q != StIdle) begin
                pend_q  <= 1'b1;
                pend_h  <= humidity;
                pend_t  <= temperature;
                dropped <= pend_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        pend_q  <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    if (done_h && done_t) begin
                        idx_q   <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    shreg_q <= frame_byte;
                    tx      <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx      <= shreg_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntMax) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx      <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx      <= shreg_q[1];
                            shreg_q <= shreg_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == CntMax) begin
                        cnt_q <= '0;
                        if (idx_q == IdxLast) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= StLoad;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dht_uart_reporter.sv
// Directed bench for dht_uart_reporter with CLKS_PER_BIT=4 and a negedge-sampling UART decoder.
module tb_dht_uart_reporter;

    localparam int Cpb     = 4;
    localparam int Timeout = 2000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       valid;
    logic       tx;
    logic       busy;
    logic       dropped;

    int checks   = 0;
    int failures = 0;
    int drop_cnt = 0;

    dht_uart_reporter #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .humidity    (humidity),
        .temperature (temperature),
        .valid       (valid),
        .tx          (tx),
        .busy        (busy),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // started=1: a start bit was already seen and the next negedge is its first sample.
    task automatic recv_byte(input bit started, output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1;
        b  = '0;
        if (started) begin
            @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (tx !== 1'b0 && n < Timeout);
            if (tx !== 1'b0) ok = 1'b0;
        end
        if (ok) begin
            repeat (Cpb + 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = tx;
                repeat (Cpb) @(negedge clk);
            end
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic check_frame(input bit started, input logic [103:0] exp, input string tag);
        logic [7:0] b;
        bit         ok;
        for (int k = 0; k < 13; k++) begin
            recv_byte(started && k == 0, b, ok);
            check($sformatf("%s byte%0d", tag, k), {23'd0, ok, b}, {23'd0, 1'b1, exp[8*(12-k) +: 8]});
        end
    endtask

    task automatic idle_window(input int cycles, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        int lat;
        int bad;
        int base;

        // Reset and long idle with valid low
        reset_n     = 1'b0;
        valid       = 1'b0;
        humidity    = 8'd0;
        temperature = 8'd0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset dropped", dropped, 0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) bad++;
        end
        check("idle after reset", bad, 0);

        // First reading: latency, contents, busy release
        humidity    = 8'd45;
        temperature = 8'd23;
        valid       = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (tx === 1'b0) break;
        end
        check("latency", lat, 10);
        check("busy in frame", busy, 1);
        check_frame(1'b1, "H=045 T=023\r\n", "f45");
        repeat (2) @(negedge clk);
        check("busy last stop", busy, 1);
        @(negedge clk);
        check("busy released", busy, 0);

        // Boundary values
        @(negedge clk);
        humidity    = 8'd0;
        temperature = 8'd255;
        check_frame(1'b0, "H=000 T=255\r\n", "f0_255");
        repeat (5) @(negedge clk);
        humidity    = 8'd9;
        temperature = 8'd100;
        check_frame(1'b0, "H=009 T=100\r\n", "f9_100");

        // Unchanged inputs with valid high: no repeats
        idle_window(3000, "no repeat");

        // Three changes during one frame: two drops, newest sent
        base        = drop_cnt;
        humidity    = 8'd50;
        temperature = 8'd60;
        fork
            check_frame(1'b0, "H=050 T=060\r\n", "f50");
            begin
                repeat (30) @(negedge clk);
                humidity = 8'd46; temperature = 8'd24;
                repeat (100) @(negedge clk);
                humidity = 8'd47; temperature = 8'd25;
                repeat (100) @(negedge clk);
                humidity = 8'd48; temperature = 8'd26;
            end
        join
        check_frame(1'b0, "H=048 T=026\r\n", "f48");
        repeat (10) @(negedge clk);
        check("drop pulses", drop_cnt - base, 2);
        idle_window(1500, "no third frame");

        // Reset during byte 5 with a pending value queued
        humidity    = 8'd11;
        temperature = 8'd22;
        repeat (100) @(negedge clk);
        humidity    = 8'd33;
        temperature = 8'd44;
        repeat (135) @(negedge clk);
        check("busy before abort", busy, 1);
        reset_n = 1'b0;
        valid   = 1'b0;
        @(posedge clk);
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_window(300, "pending cleared");
        humidity    = 8'd77;
        temperature = 8'd88;
        valid       = 1'b1;
        check_frame(1'b0, "H=077 T=088\r\n", "f77");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht_uart_reporter.md
Name: dht_uart_reporter

Overview:
- Downstream consumer of the DHT11 reader's outputs: humidity[7:0], temperature[7:0] and the level-type valid flag.
- Captures each new reading and converts both values to 3-digit decimal ASCII.
- Transmits one 13-byte text line per reading over an 8N1 UART TX pin, e.g. "H=045 T=023\r\n".
- Gives the board a human-readable sensor log with no CPU.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range is 2 or more.
- FRAME_LEN, 13, bytes per report line; fixed, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- humidity  input  8  humidity reading from the DHT11 reader, binary 0..255.
- temperature  input  8  temperature reading from the DHT11 reader, binary 0..255.
- valid  input  1  reader data-valid level; stays high once the first reading is done.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high from capture until the end of the last stop bit of the line.
- dropped  output  1  one-cycle pulse when a pending reading is overwritten before it is sent.

Behaviour:
- Reset: on a clk edge with reset_n low:
  - tx=1, busy=0, dropped=0, pending=0.
  - last_h=0, last_t=0, last_valid=0, FSM=IDLE.
  - Reset mid-frame aborts immediately; tx is high on the next cycle, with no partial stop bit.
- New-sample event (registered compare, one cycle):
  - new = valid & (~last_valid | humidity != last_h | temperature != last_t).
  - On new, last_h and last_t are loaded with the current inputs. last_valid follows valid every cycle.
- Capture:
  - In IDLE with new, or with pending set: latch cap_h and cap_t (from the inputs, or from the pending buffer). Clear pending, set busy, go to CONVERT.
  - When new occurs in any non-IDLE state: store the value in the pending buffer.
  - If pending was already 1 at that moment, overwrite it and pulse dropped for one cycle. Only the newest value is kept.
  - new and frame completion in the same cycle: the value goes to pending and is sent next; no drop.
- FSM states: IDLE, CONVERT, LOAD, START, DATA, STOP.
  - IDLE -> CONVERT on capture.
  - CONVERT: two bin2bcd8 instances run in parallel for 8 iterations. -> LOAD when both report done.
  - LOAD: select byte[idx] from the frame ROM/mux; idx starts at 0. -> START.
  - START: tx=0 for CLKS_PER_BIT cycles. -> DATA.
  - DATA: send 8 bits LSB first, each CLKS_PER_BIT cycles. -> STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if idx==12: busy=0, go to IDLE. Otherwise idx++ and go to LOAD.
- Inter-byte timing: LOAD costs one cycle, so the gap between a stop bit and the next start bit is exactly 1 clk.
- Frame bytes in order:
  - 'H' 0x48, '=' 0x3D, h_hundreds, h_tens, h_ones, ' ' 0x20.
  - 'T' 0x54, '=' 0x3D, t_hundreds, t_tens, t_ones, CR 0x0D, LF 0x0A.
  - Digit byte = 0x30 + BCD nibble. Leading zeros are always printed; 0 -> "000", 255 -> "255".
- Latency: tx falls for the first start bit exactly 10 clk cycles after the cycle in which new is registered. The breakdown is 1 capture + 8 conversion + 1 load.
- Baud counter: counts 0..CLKS_PER_BIT-1, then wraps. The bit index wraps 7->0 on leaving DATA.
- tx is a registered output with no combinational glitches.

Decomposition:
- Shared package dht_pkg:
  - FSM state enum.
  - ASCII constants (CH_H, CH_T, CH_EQ, CH_SP, CH_CR, CH_LF, ASCII_ZERO).
  - FRAME_LEN=13.
- Sub-module bin2bcd8 (sequential double-dabble):
  - Ports: clk, reset_n, start, bin[7:0], bcd[11:0], done.
  - 8 iterations after start; done is a one-cycle pulse.
  - Instantiated twice, once for humidity and once for temperature.

Test Plan:
- Reset_n low for 3 cycles, then release with valid=0 -> tx stays 1, busy=0, and no transition for 10000 cycles.
- CLKS_PER_BIT=4; humidity=45, temperature=23; valid rises -> UART monitor decodes "H=045 T=023\r\n" (13 bytes); tx falls 10 cycles after the registered valid; busy drops after the final stop bit.
- Boundaries: humidity=0, temperature=255 -> "H=000 T=255\r\n". Then humidity=9, temperature=100 -> "H=009 T=100\r\n".
- valid held high with the inputs changed 3 times during one frame (46/24, then 47/25, then 48/26) -> exactly 2 dropped pulses. Exactly 2 frames are sent: the original, then "H=048 T=026\r\n".
- valid held high with unchanged inputs -> exactly one frame, with no repeats for 5 frame-times.
- reset_n asserted during byte 5 -> tx=1 on the next cycle, busy=0, pending cleared. After release, a new valid rise sends a complete, correct line.
